// File: rtl/sisc_pkg.sv
// sisc_pkg
// Shared definitions for the SISC core: default datapath widths, the fetch
// state encoding, and the opcode field layout used by fetch to spot HALT.
// The HALTED state and the is_halt helper are only used when the core is
// built with SISC_FETCH_HALT_EN defined.

package sisc_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 32;

  // Opcode field occupies the top nibble of every instruction word.
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 28;
  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

  localparam logic [OPC_W-1:0] OPC_HALT = 4'hF;

  // Fetch FSM encoding, kept as plain constants so older tools and the
  // existing decode-side debug scripts can keep matching raw state values.
  typedef logic [2:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE    = 3'd0;
  localparam fetch_state_t ST_REQ     = 3'd1;
  localparam fetch_state_t ST_HOLD    = 3'd2;
  localparam fetch_state_t ST_DISCARD = 3'd3;
  localparam fetch_state_t ST_HALTED  = 3'd4;

  function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB] == OPC_HALT;
  endfunction

endpackage

// File: rtl/sisc_pc.sv
// sisc_pc
// Program counter register for the fetch stage. Reset has top priority, then
// a branch load, then the post-fetch increment. The increment wraps naturally
// from all-ones back to zero.
//
// Ports:
//   clk     core clock, rising edge
//   rst     synchronous active-high reset, loads RESET_PC
//   load    load target into the PC this cycle
//   target  branch target address
//   inc     advance the PC by one word
//   pc      current program counter

module sisc_pc
  import sisc_pkg::*;
#(
  parameter int                    ADDR_W   = sisc_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] target,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= target;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/sisc_fetch.sv
// sisc_fetch
// Instruction fetch stage of the SISC core. Requests one word at a time from
// instruction memory (req held until ack), latches it into the IR and offers
// it to decode with a valid/ready handshake. No prefetch: the next request
// only starts once decode has taken the current instruction. A taken branch
// from execute redirects the PC; a request already on the bus cannot be
// withdrawn, so its eventual ack is swallowed in DISCARD.
//
// Build option: define SISC_FETCH_HALT_EN to make opcode 4'hF stop fetch in a
// terminal HALTED state (left only by rst) and to add the 'halted' output.
//
// Ports:
//   clk, rst    core clock and synchronous active-high reset
//   imem_req    request to instruction memory, held until imem_ack
//   imem_addr   requested word address (the PC)
//   imem_ack    one-cycle pulse, imem_data valid
//   imem_data   returned instruction word
//   ir          instruction register presented to decode
//   ir_valid    ir holds an instruction not yet consumed
//   ir_ready    decode accepts ir this cycle
//   br_taken    execute redirects fetch this cycle
//   br_target   redirect address
//   halted      (SISC_FETCH_HALT_EN only) fetch stopped on HALT
//   pc_out      address of the instruction currently in ir

module sisc_fetch
  import sisc_pkg::*;
#(
  parameter int                ADDR_W   = sisc_pkg::ADDR_W,
  parameter int                INSTR_W  = sisc_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
`ifdef SISC_FETCH_HALT_EN
  output logic               halted,
`endif
  output logic [ADDR_W-1:0]  pc_out
);

  fetch_state_t      state;
  fetch_state_t      next_state;
  logic [ADDR_W-1:0] pc;
  logic              pc_load;
  logic              pc_inc;
  logic              capture;

  sisc_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk    (clk),
    .rst    (rst),
    .load   (pc_load),
    .target (br_target),
    .inc    (pc_inc),
    .pc     (pc)
  );

  // Next-state and PC control. A branch always redirects the PC; whether the
  // FSM can go straight to REQ depends on whether a request is still in flight
  // without its ack.
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = br_taken;
    case (state)
      ST_IDLE: begin
        next_state = ST_REQ;
      end
      ST_REQ: begin
        if (br_taken) begin
          next_state = imem_ack ? ST_REQ : ST_DISCARD;
        end else if (imem_ack) begin
          next_state = ST_HOLD;
          capture    = 1'b1;
          pc_inc     = 1'b1;
        end
      end
      ST_HOLD: begin
        if (br_taken) begin
          next_state = ST_REQ;
        end else if (ir_ready) begin
`ifdef SISC_FETCH_HALT_EN
          next_state = is_halt(ir) ? ST_HALTED : ST_REQ;
`else
          next_state = ST_REQ;
`endif
        end
      end
      ST_DISCARD: begin
        if (imem_ack) begin
          next_state = ST_REQ;
        end
      end
`ifdef SISC_FETCH_HALT_EN
      ST_HALTED: begin
        next_state = ST_HALTED;
        pc_load    = 1'b0;
      end
`endif
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // State, IR and handshake registers. ir_valid drops on consumption or on
  // any branch; a branch coinciding with ir_ready counts as one consumption.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      ir       <= '0;
      ir_valid <= 1'b0;
      pc_out   <= '0;
    end else begin
      state <= next_state;
      if (capture) begin
        ir       <= imem_data;
        pc_out   <= pc;
        ir_valid <= 1'b1;
      end else if (br_taken || (state == ST_HOLD && ir_ready)) begin
        ir_valid <= 1'b0;
      end
    end
  end

  assign imem_req  = (state == ST_REQ) || (state == ST_DISCARD);
  assign imem_addr = pc;

`ifdef SISC_FETCH_HALT_EN
  assign halted = (state == ST_HALTED);
`endif

endmodule

// File: tb/tb_sisc_fetch.sv
// tb_sisc_fetch
// Directed bench for sisc_fetch. Each cycle's inputs are applied right after
// a rising edge and outputs are sampled 1 time unit after the next edge, so
// every check sees the registered result of the cycle just driven. Memory is
// modelled by hand: the expected word and ack timing are written inline.
// Build with SISC_FETCH_HALT_EN defined to also exercise the HALT path.

`timescale 1ns/1ps

module tb_sisc_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] ir;
  logic        ir_valid;
  logic        ir_ready;
  logic        br_taken;
  logic [15:0] br_target;
  logic [15:0] pc_out;
`ifdef SISC_FETCH_HALT_EN
  logic        halted;
`endif

  int checks   = 0;
  int failures = 0;

  sisc_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .ir        (ir),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .br_taken  (br_taken),
    .br_target (br_target),
`ifdef SISC_FETCH_HALT_EN
    .halted    (halted),
`endif
    .pc_out    (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, let the edge happen, then settle before sampling.
  task automatic applyStimulus(input logic ack, input logic [31:0] data,
                               input logic ready, input logic br,
                               input logic [15:0] tgt);
    imem_ack  = ack;
    imem_data = data;
    ir_ready  = ready;
    br_taken  = br;
    br_target = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  initial begin
    rst       = 1'b1;
    imem_ack  = 1'b0;
    imem_data = '0;
    ir_ready  = 1'b0;
    br_taken  = 1'b0;
    br_target = '0;
    @(posedge clk);
    #1;

    // Reset state
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 16'h0);
    checkOutput("rst_req",    imem_req,  0);
    checkOutput("rst_addr",   imem_addr, 16'h0000);
    checkOutput("rst_ir",     ir,        32'h0);
    checkOutput("rst_valid",  ir_valid,  0);
    checkOutput("rst_pc_out", pc_out,    16'h0000);
`ifdef SISC_FETCH_HALT_EN
    checkOutput("rst_halted", halted,    0);
`endif
    rst = 1'b0;

    // IDLE -> REQ
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 16'h0);

    // Zero-wait synchronous memory: address cycle, ack cycle, HOLD cycle
    for (int n = 0; n < 3; n++) begin
      checkOutput("seq_req",   imem_req,  1);
      checkOutput("seq_addr",  imem_addr, n);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 16'h0);
      checkOutput("seq_wait_valid", ir_valid, 0);
      applyStimulus(1'b1, 32'h1000_0000 + n, 1'b1, 1'b0, 16'h0);
      checkOutput("seq_valid",  ir_valid, 1);
      checkOutput("seq_ir",     ir,       32'h1000_0000 + n);
      checkOutput("seq_pc_out", pc_out,   n);
      checkOutput("seq_hold_req", imem_req, 0);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 16'h0);
      checkOutput("seq_consumed", ir_valid, 0);
    end

    // Ack delayed by 4 cycles: request and address stay put
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 16'h0);
      checkOutput("dly_req",   imem_req,  1);
      checkOutput("dly_addr",  imem_addr, 16'h0003);
      checkOutput("dly_valid", ir_valid,  0);
    end
    applyStimulus(1'b1, 32'h1000_0003, 1'b0, 1'b0, 16'h0);
    checkOutput("dly_valid_rise", ir_valid, 1);
    checkOutput("dly_ir",         ir,       32'h1000_0003);

    // Decode stalls 5 cycles; a stray ack in HOLD must be ignored
    for (int k = 0; k < 5; k++) begin
      applyStimulus(k == 2, 32'h5555_5555, 1'b0, 1'b0, 16'h0);
      checkOutput("stall_ir",     ir,       32'h1000_0003);
      checkOutput("stall_pc_out", pc_out,   16'h0003);
      checkOutput("stall_req",    imem_req, 0);
      checkOutput("stall_valid",  ir_valid, 1);
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 16'h0);
    checkOutput("resume_req",   imem_req,  1);
    checkOutput("resume_addr",  imem_addr, 16'h0004);
    checkOutput("resume_valid", ir_valid,  0);

    // Branch during outstanding request -> DISCARD, squashed data dropped
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 16'h0040);
    checkOutput("disc_req",   imem_req,  1);
    checkOutput("disc_addr",  imem_addr, 16'h0040);
    checkOutput("disc_valid", ir_valid,  0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 16'h0);
    checkOutput("disc_hold_req", imem_req, 1);
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 16'h0);
    checkOutput("disc_drop_valid", ir_valid,  0);
    checkOutput("disc_drop_ir",    ir,        32'h1000_0003);
    checkOutput("disc_new_addr",   imem_addr, 16'h0040);
    checkOutput("disc_new_req",    imem_req,  1);
    applyStimulus(1'b1, 32'h2000_0040, 1'b0, 1'b0, 16'h0);
    checkOutput("tgt_ir",     ir,       32'h2000_0040);
    checkOutput("tgt_pc_out", pc_out,   16'h0040);
    checkOutput("tgt_valid",  ir_valid, 1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 16'h0);
    checkOutput("tgt_next_addr", imem_addr, 16'h0041);

    // Branch with ack in the same REQ cycle: data dropped, refetch at target
    applyStimulus(1'b1, 32'hBAD0_0000, 1'b0, 1'b1, 16'hFFFF);
    checkOutput("brack_req",   imem_req,  1);
    checkOutput("brack_addr",  imem_addr, 16'hFFFF);
    checkOutput("brack_valid", ir_valid,  0);
    checkOutput("brack_ir",    ir,        32'h2000_0040);
    applyStimulus(1'b1, 32'h3000_FFFF, 1'b0, 1'b0, 16'h0);
    checkOutput("wrap_pc_out", pc_out, 16'hFFFF);
    checkOutput("wrap_ir",     ir,     32'h3000_FFFF);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 16'h0);
    checkOutput("wrap_addr", imem_addr, 16'h0000);
    checkOutput("wrap_req",  imem_req,  1);

    // Branch and ready together in HOLD: branch wins
    applyStimulus(1'b1, 32'h4000_0000, 1'b0, 1'b0, 16'h0);
    checkOutput("brrdy_pc_out", pc_out, 16'h0000);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 16'h0100);
    checkOutput("brrdy_addr",  imem_addr, 16'h0100);
    checkOutput("brrdy_valid", ir_valid,  0);
    checkOutput("brrdy_req",   imem_req,  1);

    // Reset mid-request, then the orphaned ack arrives in IDLE
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 16'h0);
    checkOutput("midrst_req",    imem_req,  0);
    checkOutput("midrst_valid",  ir_valid,  0);
    checkOutput("midrst_addr",   imem_addr, 16'h0000);
    checkOutput("midrst_ir",     ir,        32'h0);
    checkOutput("midrst_pc_out", pc_out,    16'h0000);
    rst = 1'b0;
    applyStimulus(1'b1, 32'hDEAD_0000, 1'b0, 1'b0, 16'h0);
    checkOutput("orphan_valid", ir_valid,  0);
    checkOutput("orphan_ir",    ir,        32'h0);
    checkOutput("orphan_req",   imem_req,  1);
    checkOutput("orphan_addr",  imem_addr, 16'h0000);

    // Words 0..3 with opcode F at address 3
    for (int n = 0; n < 4; n++) begin
      applyStimulus(1'b1, (n == 3) ? 32'hF000_0000 : 32'h1000_0000 + n,
                    1'b0, 1'b0, 16'h0);
      checkOutput("hlt_ir", ir, (n == 3) ? 32'hF000_0000 : 32'h1000_0000 + n);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 16'h0);
    end
`ifdef SISC_FETCH_HALT_EN
    checkOutput("hlt_halted", halted,   1);
    checkOutput("hlt_req",    imem_req, 0);
    checkOutput("hlt_valid",  ir_valid, 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 32'h1234_5678, 1'b1, 1'b1, 16'h0200);
      checkOutput("hlt_stay_halted", halted,   1);
      checkOutput("hlt_stay_req",    imem_req, 0);
      checkOutput("hlt_stay_valid",  ir_valid, 0);
    end
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 16'h0);
    rst = 1'b0;
    checkOutput("hlt_rst_halted", halted, 0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 16'h0);
    checkOutput("hlt_rst_req", imem_req, 1);
`else
    checkOutput("opcF_req",  imem_req,  1);
    checkOutput("opcF_addr", imem_addr, 16'h0004);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sisc_fetch.md
Name: sisc_fetch

Overview:
Instruction fetch stage for the SISC processor. It sits directly upstream of decode/control inside the sisc top level, and is driven by the same clk and reset as the rest of the core.
- Owns the 16-bit program counter.
- Issues requests to instruction memory over a req/ack handshake.
- Latches the returned word into the instruction register (IR).
- Presents the IR to decode with a valid/ready handshake.
- Redirects the PC on a taken branch from execute.

Parameters:
ADDR_W, 16, PC and instruction-memory address width in bits.
INSTR_W, 32, instruction word width.
RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
clk  in  1  core clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
imem_req  out  1  request to instruction memory; held until imem_ack.
imem_addr  out  ADDR_W  address of the requested word; equals pc while imem_req=1.
imem_ack  in  1  one-cycle pulse: imem_data is valid this cycle.
imem_data  in  INSTR_W  instruction word returned by memory.
ir  out  INSTR_W  instruction register to decode.
ir_valid  out  1  ir holds an instruction not yet consumed.
ir_ready  in  1  decode accepts ir this cycle when ir_valid=1.
br_taken  in  1  execute redirects fetch this cycle.
br_target  in  ADDR_W  redirect address.
pc_out  out  ADDR_W  address of the instruction currently in ir (for PC-relative branches).

Behaviour:
- Reset (rst=1 at an edge), regardless of state:
  - pc=RESET_PC, state=IDLE, imem_req=0, ir=0, ir_valid=0, pc_out=0.
  - Reset overrides everything, including mid-request; a later imem_ack belonging to the aborted request is ignored because state is IDLE.
- FSM states: IDLE, REQ, HOLD, DISCARD.
  - IDLE: imem_req=0. Next cycle -> REQ.
  - REQ: imem_req=1, imem_addr=pc. Stay until imem_ack. On ack: ir<=imem_data, pc_out<=pc, pc<=pc+1 (wraps 16'hFFFF->16'h0000), ir_valid<=1, -> HOLD.
  - HOLD: ir_valid=1, imem_req=0. On ir_ready: ir_valid<=0, -> REQ next cycle.
  - DISCARD: imem_req stays 1 until imem_ack arrives for the squashed request. The data is dropped, then -> REQ at the new pc.
- Minimum throughput: one instruction per 3 cycles with zero-wait memory (REQ, HOLD, and the ack cycle overlapping REQ). No prefetch.
- Branch (br_taken=1):
  - pc<=br_target and ir_valid<=0 in every state.
  - If in REQ with no ack this cycle: -> DISCARD (an outstanding request cannot be retracted).
  - If in REQ with ack the same cycle: the data is dropped and -> REQ at the target.
  - From HOLD or IDLE: -> REQ.
- Simultaneous br_taken and ir_ready in HOLD: the branch wins. The instruction counts as consumed and fetch restarts at br_target.
- Branch while in DISCARD: pc updated again, remain in DISCARD.
- imem_ack while in IDLE or HOLD: ignored.
- Latency: a branch asserted in cycle N gives imem_addr=br_target in cycle N+1 (or after the squashed ack).

Optional Feature:
SISC_FETCH_HALT_EN.
- Defined: when the latched IR has opcode bits [31:28]=4'hF (HALT), fetch enters a terminal HALTED state after decode consumes it. imem_req=0 and ir_valid=0 in HALTED; only rst leaves it. Adds output halted (1 bit, reset 0, 1 in HALTED).
- Undefined: opcode 4'hF is treated as an ordinary instruction and the halted port is absent.

Decomposition:
- Package sisc_pkg: ADDR_W/INSTR_W defaults, fetch state enum, OPC_HALT=4'hF, opcode field slice constants.
- One natural sub-module: sisc_pc (PC register with reset load, increment, branch load). The FSM and IR stay in sisc_fetch.

Test Plan:
- Reset then zero-wait memory, ir_ready=1, memory[n]=32'h1000_0000+n -> imem_addr sequence 0,1,2; ir sequence 32'h1000_0000, 32'h1000_0001, 32'h1000_0002; one ir_valid pulse every 3 cycles.
- imem_ack delayed 4 cycles -> imem_req and imem_addr held stable all 4 cycles; ir_valid rises the cycle after ack.
- ir_ready=0 for 5 cycles in HOLD -> ir and pc_out stable, imem_req=0; fetch resumes after ready.
- br_taken with br_target=16'h0040 during an outstanding request -> DISCARD; the squashed ack data never reaches ir; next imem_addr=16'h0040.
- PC at 16'hFFFF -> next imem_addr=16'h0000; rst asserted mid-REQ -> next cycle imem_req=0, ir_valid=0, pc=RESET_PC.
- With SISC_FETCH_HALT_EN: word 32'hF000_0000 at address 3 -> halted=1 after it is consumed, no further imem_req until rst.
